// File: rtl/reram_wb_ctrl.sv
// reram_wb_ctrl: Wishbone classic slave sitting in front of the ReRAM core.
// Each bus cycle becomes an EN/R_WB command strobe to the core. The strobe is
// held until the core returns func_ack. The block tracks core occupancy,
// aborts a command that gets no response within TIMEOUT_CYC, keeps sticky
// status flags and closes every bus cycle with a one-cycle wbs_ack_o.
//
// Ports:
//   wb_clk_i, wb_rst_i          clock, synchronous active-high reset
//   wbs_cyc_i/stb_i/we_i        Wishbone cycle, strobe and direction
//   wbs_sel_i                   byte select (ignored, full-word accesses only)
//   wbs_adr_i, wbs_dat_i        address and write data
//   wbs_ack_o, wbs_dat_o        one-cycle acknowledge and read data
//   EN, R_WB, core_dat_o        core command strobe, direction (1 = read), command word
//   read_data, func_ack         core read result and completion
//
// Register map (offset = adr[3:2]):
//   0 DATA    write issues a core write, read issues a core read
//   1 STATUS  {24'b0, ovf, unf, tmo, busy, occ[3:0]}
//             writing 1 to a flag bit (7 ovf, 6 unf, 5 tmo) clears that flag
//   2         reads 0, writes ignored
//   3         reads 0, writes ignored; when RERAM_WB_PERF_EN is defined it reads
//             {wr_done, rd_done} and any write clears both counters
//
// States:
//   IDLE  | waiting for a decoded bus request
//   WR    | core write in flight, EN high, R_WB low
//   RD    | core read in flight, EN and R_WB held high
//   DRAIN | waiting for func_ack to fall before responding
//   RESP  | issue the single-cycle wbs_ack_o
module reram_wb_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          DEPTH       = 32,
    parameter int          TIMEOUT_CYC = 64,
    parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        EN,
    output logic        R_WB,
    output logic [31:0] core_dat_o,
    input  logic [31:0] read_data,
    input  logic        func_ack
);

    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [OCC_W-1:0] OCC_MAX  = OCC_W'(DEPTH);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {IDLE, WR, RD, DRAIN, RESP} state_t;

    state_t           state;
    logic [OCC_W-1:0] occ;
    logic [TMR_W-1:0] timer;
    logic             ovf, unf, tmo;
`ifdef RERAM_WB_PERF_EN
    logic [15:0]      wr_done, rd_done;
`endif

    logic        decode, req;
    logic [1:0]  offset;
    logic [3:0]  occ_sat;
    logic [31:0] status_word;
    logic        unused_bits;

    assign decode      = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign offset      = wbs_adr_i[3:2];
    // The master still holds stb during the ack cycle; it must not start a new request.
    assign req         = wbs_cyc_i & wbs_stb_i & decode & ~wbs_ack_o;
    assign occ_sat     = (occ > OCC_W'(15)) ? 4'hF : occ[3:0];
    assign status_word = {24'b0, ovf, unf, tmo, (state != IDLE), occ_sat};
    assign unused_bits = ^{wbs_sel_i, wbs_adr_i[1:0]};

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state      <= IDLE;
            occ        <= '0;
            timer      <= '0;
            ovf        <= 1'b0;
            unf        <= 1'b0;
            tmo        <= 1'b0;
            EN         <= 1'b0;
            R_WB       <= 1'b0;
            wbs_ack_o  <= 1'b0;
            wbs_dat_o  <= '0;
            core_dat_o <= '0;
`ifdef RERAM_WB_PERF_EN
            wr_done    <= '0;
            rd_done    <= '0;
`endif
        end else begin
            wbs_ack_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        wbs_dat_o <= '0;
                        timer     <= TMR_LOAD;
                        state     <= RESP;
                        case (offset)
                            2'd0: begin
                                if (wbs_we_i) begin
                                    if (occ < OCC_MAX) begin
                                        state      <= WR;
                                        EN         <= 1'b1;
                                        R_WB       <= 1'b0;
                                        core_dat_o <= wbs_dat_i;
                                    end else begin
                                        ovf <= 1'b1;
                                    end
                                end else begin
                                    if (occ != '0) begin
                                        state <= RD;
                                        EN    <= 1'b1;
                                        R_WB  <= 1'b1;
                                    end else begin
                                        unf       <= 1'b1;
                                        wbs_dat_o <= ERR_DATA;
                                    end
                                end
                            end
                            2'd1: begin
                                if (wbs_we_i) begin
                                    if (wbs_dat_i[7]) ovf <= 1'b0;
                                    if (wbs_dat_i[6]) unf <= 1'b0;
                                    if (wbs_dat_i[5]) tmo <= 1'b0;
                                end else begin
                                    wbs_dat_o <= status_word;
                                end
                            end
                            2'd2: ;
                            default: begin
`ifdef RERAM_WB_PERF_EN
                                if (wbs_we_i) begin
                                    wr_done <= '0;
                                    rd_done <= '0;
                                end else begin
                                    wbs_dat_o <= {wr_done, rd_done};
                                end
`endif
                            end
                        endcase
                    end
                end
                WR, RD: begin
                    if (func_ack) begin
                        EN    <= 1'b0;
                        R_WB  <= 1'b0;
                        state <= DRAIN;
                        if (state == WR) begin
                            if (occ != OCC_MAX) occ <= occ + 1'b1;
`ifdef RERAM_WB_PERF_EN
                            wr_done <= wr_done + 16'd1;
`endif
                        end else begin
                            wbs_dat_o <= read_data;
                            if (occ != '0) occ <= occ - 1'b1;
`ifdef RERAM_WB_PERF_EN
                            rd_done <= rd_done + 16'd1;
`endif
                        end
                    end else if (timer == '0) begin
                        EN    <= 1'b0;
                        R_WB  <= 1'b0;
                        tmo   <= 1'b1;
                        state <= DRAIN;
                        if (state == RD) wbs_dat_o <= ERR_DATA;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                DRAIN: begin
                    // A func_ack still high here belongs to the command already counted.
                    if (!func_ack) state <= RESP;
                end
                RESP: begin
                    // A master that abandoned the cycle gets no acknowledge.
                    wbs_ack_o <= wbs_cyc_i;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reram_wb_ctrl.sv
module tb_reram_wb_ctrl;

    localparam logic [31:0] A_DATA = 32'h3000_0000;
    localparam logic [31:0] A_STAT = 32'h3000_0004;
    localparam logic [31:0] A_R2   = 32'h3000_0008;
    localparam logic [31:0] A_R3   = 32'h3000_000C;
    localparam logic [31:0] ERR    = 32'hDEAD_BEEF;
`ifdef RERAM_WB_PERF_EN
    localparam logic [31:0] PERF_V11 = 32'h0001_0001;
`else
    localparam logic [31:0] PERF_V11 = 32'h0000_0000;
`endif

    logic        clk = 1'b0;
    logic        rst, cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic        ack, en, r_wb;
    logic [31:0] dat_o, core_dat;
    logic [31:0] read_data = 32'h5A5A_5A5A;
    logic        func_ack  = 1'b0;

    always #5 clk = ~clk;

    reram_wb_ctrl dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (wdat),
        .wbs_ack_o (ack),
        .wbs_dat_o (dat_o),
        .EN        (en),
        .R_WB      (r_wb),
        .core_dat_o(core_dat),
        .read_data (read_data),
        .func_ack  (func_ack)
    );

    // Core model: raises func_ack after seeing EN for core_delay cycles
    // (0 = never answers) and holds it for core_hold cycles.
    int          core_delay = 0, core_hold = 1;
    logic [31:0] core_rdata = '0;
    int          en_seen = 0, ack_left = 0;

    always @(negedge clk) begin
        if (ack_left > 0) begin
            ack_left--;
            if (ack_left == 0) begin
                func_ack  = 1'b0;
                read_data = 32'h5A5A_5A5A;
            end
        end else if (en && core_delay > 0) begin
            en_seen++;
            if (en_seen == core_delay) begin
                func_ack  = 1'b1;
                read_data = core_rdata;
                ack_left  = core_hold;
                en_seen   = 0;
            end
        end else if (!en) begin
            en_seen = 0;
        end
    end

    int en_cycles = 0, enr_cycles = 0, ack_cnt = 0;
    always @(negedge clk) begin
        if (en) en_cycles++;
        if (en && r_wb) enr_cycles++;
        if (ack) ack_cnt++;
    end

    int n_cmp = 0, n_fail = 0;
    int last_lat, last_en, last_enr, last_acks;
    logic [31:0] last_rd;
    logic [31:0] sb_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic set_core(input int d, input int h, input logic [31:0] r);
        core_delay = d;
        core_hold  = h;
        core_rdata = r;
    endtask

    task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d);
        int en0, enr0, ack0;
        bit ok;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
        en0 = en_cycles; enr0 = enr_cycles; ack0 = ack_cnt;
        ok = 1'b0;
        last_lat = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(posedge clk); #1;
            last_lat++;
            if (ack) begin
                ok      = 1'b1;
                last_rd = dat_o;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        last_en   = en_cycles - en0;
        last_enr  = enr_cycles - enr0;
        last_acks = ack_cnt - ack0;
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL bus_ack: no wbs_ack_o within 200 cycles at adr %h, expected an ack", a);
        end
    endtask

    // Expected read data is queued when the request is driven and compared when the ack returns.
    task automatic xfer(input string nm, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp, input bit chkd);
        if (chkd) sb_q.push_back(exp);
        bus(w, a, d);
        if (chkd) chk(nm, last_rd, sb_q.pop_front());
    endtask

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        int          dly;
        int          hold;
        logic [31:0] rdat;
        logic [31:0] exp;
        bit          chkd;
        int          lat;
        int          en_n;
    } vec_t;

    vec_t vt[14];

    initial begin
        vt[0]  = '{1'b0, A_STAT, 32'h0,          0,  1, 32'h0,  32'h00,     1'b1, 2,  0};
        vt[1]  = '{1'b1, A_DATA, 32'h0420_00AB,  1,  1, 32'h0,  32'h00,     1'b0, 4,  1};
        vt[2]  = '{1'b0, A_STAT, 32'h0,          0,  1, 32'h0,  32'h01,     1'b1, 2,  0};
        vt[3]  = '{1'b0, A_DATA, 32'h0,          44, 2, 32'hAB, 32'hAB,     1'b1, 48, 44};
        vt[4]  = '{1'b0, A_STAT, 32'h0,          0,  1, 32'h0,  32'h00,     1'b1, 2,  0};
        vt[5]  = '{1'b0, A_DATA, 32'h0,          0,  1, 32'h0,  ERR,        1'b1, 2,  0};
        vt[6]  = '{1'b0, A_STAT, 32'h0,          0,  1, 32'h0,  32'h40,     1'b1, 2,  0};
        vt[7]  = '{1'b1, A_STAT, 32'h40,         0,  1, 32'h0,  32'h00,     1'b0, 2,  0};
        vt[8]  = '{1'b0, A_STAT, 32'h0,          0,  1, 32'h0,  32'h00,     1'b1, 2,  0};
        vt[9]  = '{1'b0, A_R2,   32'h0,          0,  1, 32'h0,  32'h00,     1'b1, 2,  0};
        vt[10] = '{1'b1, A_R2,   32'hFFFF_FFFF,  0,  1, 32'h0,  32'h00,     1'b0, 2,  0};
        vt[11] = '{1'b0, A_R3,   32'h0,          0,  1, 32'h0,  PERF_V11,   1'b1, 2,  0};
        vt[12] = '{1'b1, A_DATA, 32'h0000_1234,  3,  1, 32'h0,  32'h00,     1'b0, 6,  3};
        vt[13] = '{1'b0, A_STAT, 32'h0,          0,  1, 32'h0,  32'h01,     1'b1, 2,  0};

        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'hF; adr = '0; wdat = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_en",   {31'b0, en},   32'h0);
        chk("rst_rwb",  {31'b0, r_wb}, 32'h0);
        chk("rst_ack",  {31'b0, ack},  32'h0);
        chk("rst_dat",  dat_o,         32'h0);
        chk("rst_cdat", core_dat,      32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            set_core(vt[i].dly, vt[i].hold, vt[i].rdat);
            xfer($sformatf("vec%0d_dat", i), vt[i].w, vt[i].a, vt[i].d, vt[i].exp, vt[i].chkd);
            chk($sformatf("vec%0d_lat", i),  32'(last_lat),  32'(vt[i].lat));
            chk($sformatf("vec%0d_en", i),   32'(last_en),   32'(vt[i].en_n));
            chk($sformatf("vec%0d_rwb", i),  32'(last_enr),  vt[i].w ? 32'd0 : 32'(vt[i].en_n));
            chk($sformatf("vec%0d_acks", i), 32'(last_acks), 32'd1);
            if (vt[i].w && vt[i].a == A_DATA)
                chk($sformatf("vec%0d_cdat", i), core_dat, vt[i].d);
        end

        // Core never answers a read: abort after TIMEOUT_CYC with occupancy untouched.
        set_core(0, 1, 32'h0);
        xfer("tmo_dat", 1'b0, A_DATA, 32'h0, ERR, 1'b1);
        chk("tmo_lat", 32'(last_lat), 32'd67);
        chk("tmo_en",  32'(last_en),  32'd64);
        xfer("tmo_stat", 1'b0, A_STAT, 32'h0, 32'h21, 1'b1);
`ifdef RERAM_WB_PERF_EN
        xfer("tmo_perf", 1'b0, A_R3, 32'h0, 32'h0002_0001, 1'b1);
`endif
        xfer("tmo_w1c", 1'b1, A_STAT, 32'h20, 32'h0, 1'b0);
        xfer("tmo_clr", 1'b0, A_STAT, 32'h0, 32'h01, 1'b1);

        // Fill to DEPTH, then one more write must bounce with ovf and no EN.
        set_core(1, 1, 32'h0);
        for (int i = 0; i < 31; i++) bus(1'b1, A_DATA, 32'(i));
        xfer("full_stat", 1'b0, A_STAT, 32'h0, 32'h0F, 1'b1);
        bus(1'b1, A_DATA, 32'hFFFF_0033);
        chk("ovf_en",  32'(last_en),  32'd0);
        chk("ovf_lat", 32'(last_lat), 32'd2);
        xfer("ovf_stat", 1'b0, A_STAT, 32'h0, 32'h8F, 1'b1);

        // 18 reads bring a clamped 32 down to 14.
        for (int i = 0; i < 18; i++) begin
            set_core(2, 1, 32'hC0DE_0000 + 32'(i));
            xfer($sformatf("drain%0d", i), 1'b0, A_DATA, 32'h0, 32'hC0DE_0000 + 32'(i), 1'b1);
        end
        xfer("drain_stat", 1'b0, A_STAT, 32'h0, 32'h8E, 1'b1);

        // Master abandons a read: the core read completes, no ack, occ still decrements.
        begin
            int en0, ack0;
            set_core(10, 1, 32'h77);
            @(negedge clk);
            en0 = en_cycles; ack0 = ack_cnt;
            cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_DATA;
            repeat (3) @(posedge clk);
            #1;
            cyc = 1'b0; stb = 1'b0;
            repeat (25) @(posedge clk);
            #1;
            chk("drop_acks", 32'(ack_cnt - ack0),   32'd0);
            chk("drop_en",   32'(en_cycles - en0),  32'd10);
        end
        xfer("drop_stat", 1'b0, A_STAT, 32'h0, 32'h8D, 1'b1);

        // Address just past the decoded window: no ack, no command.
        begin
            int en0, ack0;
            set_core(0, 1, 32'h0);
            @(negedge clk);
            en0 = en_cycles; ack0 = ack_cnt;
            cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3000_0010; wdat = 32'h1;
            repeat (12) @(posedge clk);
            #1;
            cyc = 1'b0; stb = 1'b0; we = 1'b0;
            chk("miss_acks", 32'(ack_cnt - ack0),  32'd0);
            chk("miss_en",   32'(en_cycles - en0), 32'd0);
        end
        xfer("miss_stat", 1'b0, A_STAT, 32'h0, 32'h8D, 1'b1);

        // Reset in the middle of a write: EN falls on the reset edge, everything clears.
        set_core(0, 1, 32'h0);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = A_DATA; wdat = 32'hAAAA_5555;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_en_hi", {31'b0, en}, 32'h1);
        @(negedge clk);
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_en_lo", {31'b0, en}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        xfer("rst_stat", 1'b0, A_STAT, 32'h0, 32'h00, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
